// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM read/write address sequencer: FSM states,
// AXI burst encodings and the captured burst descriptor.
package sram_arb_pkg;

    localparam int ARB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [7:0]            len;
    } arb_desc_t;

    // A beat is mis-counted when "last" disagrees with "no beats remain".
    function automatic logic len_mismatch(input logic last, input logic cnt_zero);
        return last ^ cnt_zero;
    endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin: bit 1 is the write request, bit 0 the read.
// The caller owns the last-grant flag and updates it on handshake.
module sram_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // On contention the direction not served last wins.
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_rw_arb.sv
// Grants AW or AR to the single SRAM address generator and holds ownership
// until the generator signals the last beat of the burst.
module sram_rw_arb
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W
) (
    input  logic                  aclk_i,
    input  logic                  areset_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [2:0]            awsize_i,
    input  logic [1:0]            awburst_i,
    input  logic [7:0]            awlen_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [2:0]            arsize_i,
    input  logic [1:0]            arburst_i,
    input  logic [7:0]            arlen_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [2:0]            asize_o,
    output logic [1:0]            aburst_o,
    output logic [7:0]            alen_o,
    output logic                  avalid_o,
    input  logic                  aready_i,
    input  logic                  beat_valid_i,
    input  logic                  beat_ready_i,
    input  logic                  beat_last_i,
    output logic                  sel_wr_o,
    output logic                  busy_o,
    output logic                  len_err_o
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    arb_desc_t  r_desc;
    logic       r_last_wr;
    logic       r_sel_wr;
    logic       r_len_err;
    logic [7:0] r_cnt;

    logic [1:0] w_grant;
    logic       w_aw_hs;
    logic       w_ar_hs;
    logic       w_beat;
    logic       w_cnt_zero;

    sram_rr_arb2 u_rr (
        .i_req        ({awvalid_i, arvalid_i}),
        .i_last_grant (r_last_wr),
        .o_grant      (w_grant)
    );

    assign w_aw_hs    = awvalid_i & awready_o;
    assign w_ar_hs    = arvalid_i & arready_o;
    assign w_beat     = (r_state == BURST) & beat_valid_i & beat_ready_i;
    assign w_cnt_zero = (r_cnt == 8'd0);

    // Readies depend only on state and AXI valids, never on generator inputs.
    always_comb begin
        w_state_nxt = r_state;
        awready_o   = 1'b0;
        arready_o   = 1'b0;
        case (r_state)
            IDLE: begin
                awready_o = w_grant[1];
                arready_o = w_grant[0];
                if (w_aw_hs || w_ar_hs) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (aready_i) w_state_nxt = BURST;
            end
            BURST: begin
                if (w_beat && beat_last_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            r_desc    <= '0;
            r_last_wr <= 1'b0;
            r_sel_wr  <= 1'b0;
            r_cnt     <= 8'd0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_beat & len_mismatch(beat_last_i, w_cnt_zero);
            if (w_aw_hs) begin
                r_desc.addr  <= ARB_ADDR_W'(awaddr_i);
                r_desc.size  <= awsize_i;
                r_desc.burst <= awburst_i;
                r_desc.len   <= awlen_i;
                r_sel_wr     <= 1'b1;
                r_last_wr    <= 1'b1;
                r_cnt        <= awlen_i;
            end else if (w_ar_hs) begin
                r_desc.addr  <= ARB_ADDR_W'(araddr_i);
                r_desc.size  <= arsize_i;
                r_desc.burst <= arburst_i;
                r_desc.len   <= arlen_i;
                r_sel_wr     <= 1'b0;
                r_last_wr    <= 1'b0;
                r_cnt        <= arlen_i;
            end else if (w_beat && !w_cnt_zero) begin
                // Saturates at zero so an over-long burst keeps flagging errors.
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign addr_o    = ADDR_WIDTH'(r_desc.addr);
    assign asize_o   = r_desc.size;
    assign aburst_o  = r_desc.burst;
    assign alen_o    = r_desc.len;
    assign avalid_o  = (r_state == ISSUE);
    assign busy_o    = (r_state != IDLE);
    assign sel_wr_o  = r_sel_wr;
    assign len_err_o = r_len_err;

endmodule
